// File: rtl/binary_game_pkg.sv
// Shared types and constants for the binary counting game controller.
package binary_game_pkg;
  localparam int         DIGIT_W   = 4;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {IDLE, LOAD, SHOW, HIT, MISS, OVER} state_e;

  // Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/game_tick_gen.sv
// Game tick divider; restart re-phases it so a tick lands TICK_DIV cycles after a state entry.
module game_tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/binary_game_controller.sv
// Round sequencer for the "count in binary" game: random target, timed match, scoring.
module binary_game_controller
  import binary_game_pkg::*;
#(
  parameter int TICK_DIV     = 10_000_000,
  parameter int ROUND_TICKS  = 10,
  parameter int RESULT_TICKS = 2,
  parameter int ROUNDS       = 9,
  parameter int MATCH_HOLD   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] sw,
  input  logic               start,
  output logic [DIGIT_W-1:0] digit,
  output logic               blank,
  output logic               led_hit,
  output logic               led_miss,
  output logic [3:0]         score,
  output logic [3:0]         round_num,
  output logic [3:0]         time_left,
  output logic               busy
);
  localparam int            MW        = $clog2(MATCH_HOLD + 1);
  localparam int            RW        = $clog2(RESULT_TICKS + 1);
  localparam logic [MW-1:0] HOLD_LAST = MW'(MATCH_HOLD - 1);
  localparam logic [RW-1:0] RES_LAST  = RW'(RESULT_TICKS - 1);

  logic [DIGIT_W-1:0] sw_m_q, sw_s_q;
  logic               start_m_q, start_s_q, start_r_q, start_p;
  logic [7:0]         lfsr_q, lfsr_d;
  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] target_q, target_d;
  logic [3:0]         score_q, score_d, round_q, round_d, time_q, time_d;
  logic [MW-1:0]      match_q, match_d;
  logic [RW-1:0]      res_q, res_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               blank_q, blank_d, hit_q, hit_d, miss_q, miss_d, busy_q, busy_d;
  logic               tick, restart;
  logic               sw_eq;

  assign start_p = start_s_q & ~start_r_q;
  assign sw_eq   = (sw_s_q == target_q);
  assign restart = (state_d != state_q);
  assign lfsr_d  = lfsr_step(lfsr_q);

  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    score_d  = score_q;
    round_d  = round_q;
    time_d   = time_q;
    match_d  = match_q;
    res_d    = res_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_p) begin
          score_d = '0;
          round_d = 4'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Never pick the value already on the switches: that would be a free hit.
        target_d = (lfsr_q[3:0] == sw_s_q) ? (lfsr_q[3:0] ^ 4'h1) : lfsr_q[3:0];
        time_d   = 4'(ROUND_TICKS);
        match_d  = '0;
        state_d  = SHOW;
      end
      SHOW: begin
        match_d = sw_eq ? match_q + MW'(1) : '0;
        if (tick) time_d = time_q - 4'd1;
        if (sw_eq && match_q == HOLD_LAST) begin
          score_d = (score_q == 4'hF) ? score_q : score_q + 4'd1;
          state_d = HIT;
        end else if (tick && time_q == 4'd1) begin
          state_d = MISS;
        end
      end
      HIT, MISS: begin
        if (tick) begin
          if (res_q == RES_LAST) begin
            if (round_q == 4'(ROUNDS)) state_d = OVER;
            else begin
              round_d = round_q + 4'd1;
              state_d = LOAD;
            end
          end else begin
            res_d = res_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart)           res_d  = '0;
    if (state_d != SHOW)   time_d = '0;
  end

  // Outputs are decoded from next-state values so they register in step with the FSM.
  always_comb begin
    digit_d = '0;
    blank_d = 1'b1;
    busy_d  = 1'b0;
    unique case (state_d)
      SHOW, HIT, MISS: begin
        digit_d = target_d;
        blank_d = 1'b0;
        busy_d  = 1'b1;
      end
      OVER: begin
        digit_d = score_d;
        blank_d = 1'b0;
      end
      default: ;
    endcase
    hit_d  = (state_d == HIT);
    miss_d = (state_d == MISS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m_q    <= '0;
      sw_s_q    <= '0;
      start_m_q <= 1'b0;
      start_s_q <= 1'b0;
      start_r_q <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      state_q   <= IDLE;
      target_q  <= '0;
      score_q   <= '0;
      round_q   <= '0;
      time_q    <= '0;
      match_q   <= '0;
      res_q     <= '0;
      digit_q   <= '0;
      blank_q   <= 1'b1;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sw_m_q    <= sw;
      sw_s_q    <= sw_m_q;
      start_m_q <= start;
      start_s_q <= start_m_q;
      start_r_q <= start_s_q;
      lfsr_q    <= lfsr_d;
      state_q   <= state_d;
      target_q  <= target_d;
      score_q   <= score_d;
      round_q   <= round_d;
      time_q    <= time_d;
      match_q   <= match_d;
      res_q     <= res_d;
      digit_q   <= digit_d;
      blank_q   <= blank_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      busy_q    <= busy_d;
    end
  end

  assign digit     = digit_q;
  assign blank     = blank_q;
  assign led_hit   = hit_q;
  assign led_miss  = miss_q;
  assign score     = score_q;
  assign round_num = round_q;
  assign time_left = time_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_binary_game_controller.sv
// Bench for binary_game_controller: round table, result scoreboard, reference LFSR model.
module tb_binary_game_controller;
  localparam int TD = 4, RT = 3, RES = 2, RN = 2, MH = 2;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] sw = 4'd0;
  logic [3:0] digit, score, round_num, time_left;
  logic       blank, led_hit, led_miss, busy;
  int         n_vec = 0, n_bad = 0;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank, led_hit, led_miss;
    logic [3:0] score, round_num, time_left;
    logic       busy;
  } out_t;

  typedef struct {
    string      nm;
    bit         do_match;
    int         dly;
    bit         exp_hit;
    int         exp_cyc;
    logic [3:0] exp_score;
    logic [3:0] rnd;
  } rv_t;

  typedef struct {
    string nm;
    out_t  o;
  } sb_t;

  out_t       cur;
  sb_t        sbq[$];
  rv_t        rv[4];
  logic [7:0] m_lfsr, m_prev;
  logic [3:0] tgt;

  assign cur = {digit, blank, led_hit, led_miss, score, round_num, time_left, busy};

  always #5 clk = ~clk;

  binary_game_controller #(
    .TICK_DIV(TD), .ROUND_TICKS(RT), .RESULT_TICKS(RES), .ROUNDS(RN), .MATCH_HOLD(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .start(start),
    .digit(digit), .blank(blank), .led_hit(led_hit), .led_miss(led_miss),
    .score(score), .round_num(round_num), .time_left(time_left), .busy(busy)
  );

  function automatic logic [7:0] lnext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lnext(m_lfsr);
    end
  end

  function automatic out_t o_mk(input logic [3:0] d, input logic b, h, m,
                                input logic [3:0] s, r, t, input logic y);
    out_t o;
    o.digit = d; o.blank = b; o.led_hit = h; o.led_miss = m;
    o.score = s; o.round_num = r; o.time_left = t; o.busy = y;
    return o;
  endfunction

  function automatic out_t o_idle();
    return o_mk(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endfunction

  // Target the DUT should have latched in LOAD, given the sampled switches.
  function automatic logic [3:0] exp_tgt(input logic [3:0] s);
    logic [3:0] l;
    l = m_prev[3:0];
    return (l == s) ? (l ^ 4'h1) : l;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp(input string nm, input out_t e);
    n_vec++;
    if (cur !== e) begin
      n_bad++;
      $display("FAIL %s: got d=%0d bl=%0b h=%0b m=%0b s=%0d r=%0d t=%0d busy=%0b, want d=%0d bl=%0b h=%0b m=%0b s=%0d r=%0d t=%0d busy=%0b",
               nm, cur.digit, cur.blank, cur.led_hit, cur.led_miss, cur.score, cur.round_num,
               cur.time_left, cur.busy, e.digit, e.blank, e.led_hit, e.led_miss, e.score,
               e.round_num, e.time_left, e.busy);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // Called at a negedge in IDLE or OVER; leaves the bench at the first SHOW sample.
  task automatic start_game(input bit collide, input logic [3:0] old_rnd);
    logic [7:0] l;
    if (collide) begin
      l  = lnext(lnext(lnext(m_lfsr)));
      sw = l[3:0];
    end
    start = 1'b1;
    cyc(2);
    chk("start_lat_round_old", round_num, old_rnd);
    cyc(1);
    chk("load_round", round_num, 4'd1);
    chk("load_score", score, 4'd0);
    chk("load_busy", busy, 1'b0);
    start = 1'b0;
    cyc(1);
    tgt = exp_tgt(sw);
    if (collide) chk("collide_target", digit, sw ^ 4'h1);
    cmp("show_entry", o_mk(tgt, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'(RT), 1'b1));
  endtask

  // Called at the first SHOW sample of a round.
  task automatic play_round(input rv_t v);
    int  k, d;
    bit  done;
    sb_t e;
    e.nm = v.nm;
    e.o  = o_mk(tgt, 1'b0, v.exp_hit, !v.exp_hit, v.exp_score, v.rnd, 4'd0, 1'b1);
    sbq.push_back(e);
    if (!v.do_match) sw = tgt ^ 4'hF;
    k = 0;
    done = 1'b0;
    while (k < 16 && !done) begin
      if (v.do_match && k == v.dly) sw = tgt;
      cyc(1);
      k++;
      if (led_hit || led_miss) done = 1'b1;
      else if (k < 12) chk({v.nm, "_time_left"}, time_left, RT - k / TD);
    end
    e = sbq.pop_front();
    if (done) cmp(e.nm, e.o);
    else begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: no result within %0d cycles", e.nm, k);
    end
    chk({v.nm, "_result_cycle"}, k, v.exp_cyc);
    d = 1;
    while (d < 20) begin
      cyc(1);
      if (!(led_hit || led_miss)) break;
      d++;
    end
    chk({v.nm, "_result_len"}, d, RES * TD);
    if (v.rnd == 4'(RN)) begin
      cmp({v.nm, "_over"}, o_mk(v.exp_score, 1'b0, 1'b0, 1'b0, v.exp_score, 4'(RN), 4'd0, 1'b0));
    end else begin
      chk({v.nm, "_next_round"}, round_num, v.rnd + 4'd1);
      cyc(1);
      tgt = exp_tgt(sw);
      cmp({v.nm, "_next_show"}, o_mk(tgt, 1'b0, 1'b0, 1'b0, v.exp_score, v.rnd + 4'd1, 4'(RT), 1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rv[0] = '{"g1r1_hit",          1'b1, 0, 1'b1, 4,  4'd1, 4'd1};
    rv[1] = '{"g1r2_miss",         1'b0, 0, 1'b0, 12, 4'd1, 4'd2};
    rv[2] = '{"g2r1_lasttick_hit", 1'b1, 8, 1'b1, 12, 4'd1, 4'd1};
    rv[3] = '{"g2r2_late_miss",    1'b1, 9, 1'b0, 12, 4'd1, 4'd2};

    cyc(3);
    cmp("reset", o_idle());
    rst_n = 1'b1;
    cyc(50);
    cmp("idle50", o_idle());

    start_game(1'b0, 4'd0);
    for (int i = 0; i < 2; i++) play_round(rv[i]);

    start_game(1'b1, 4'(RN));
    for (int i = 2; i < 4; i++) play_round(rv[i]);

    // Start presses during SHOW and HIT must not disturb the game.
    start_game(1'b0, 4'(RN));
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    cyc(2);
    cmp("start_ignored_show", o_mk(tgt, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd2, 1'b1));
    sw = tgt;
    cyc(4);
    cmp("g3_hit", o_mk(tgt, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 1'b1));
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    cyc(2);
    cmp("start_ignored_hit", o_mk(tgt, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 4'd0, 1'b1));
    cyc(3);
    chk("g3_next_round", round_num, 4'd2);
    cyc(1);
    tgt = exp_tgt(sw);
    cmp("g3_r2_show", o_mk(tgt, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'(RT), 1'b1));

    cyc(2);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset_midcycle", o_idle());
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    cmp("idle_after_reset", o_idle());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
